angular_filter_accum: RTL and testbench
=======================================

Name: angular_filter_accum

Overview:
- Consumer of the four tap products produced by the multiple-constant multipliers in the intra angular datapath.
- Sums the products for one predicted sample, adds the rounding offset, normalises by 2^SHIFT and clips to the pixel range.
- Sits between the MCM array and the prediction-sample buffer.
- Adds valid/ready flow control and per-row sample counting with a last-sample marker.

Parameters:
- PROD_W, 16, width of each signed tap product.
- SUM_W, 18, internal signed accumulation width; must be ≥ PROD_W+2.
- SHIFT, 6, normalisation shift; the filter coefficients sum to 64.
- BIT_DEPTH, 8, output pixel width.
- N_SAMPLES, 16, predicted samples per row; the counter wraps at this value.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, tap products are valid this cycle.
- in_ready, out, 1, block can accept a beat this cycle.
- in_p0, in, PROD_W, signed product, tap 0.
- in_p1, in, PROD_W, signed product, tap 1.
- in_p2, in, PROD_W, signed product, tap 2.
- in_p3, in, PROD_W, signed product, tap 3.
- in_last, in, 1, upstream marks the final sample of a row.
- out_valid, out, 1, output sample is valid.
- out_ready, in, 1, downstream accepts the output sample.
- out_pix, out, BIT_DEPTH, clipped predicted sample.
- out_last, out, 1, output sample is index N_SAMPLES-1 of its row.
- err_sync, out, 1, sticky flag: in_last arrived at the wrong index.

Behaviour:
- Reset (async assert, sync deassert):
  - Both stage-valid bits = 0; out_valid = 0, out_pix = 0, out_last = 0, err_sync = 0.
  - Sample counter = 0.
  - in_ready = 1 as soon as reset is released.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Outputs hold stable while out_valid && !out_ready.
  - in_ready is combinational: (!s1_valid) || (!s2_valid) || out_ready. This gives full throughput and no bubbles.
  - Each stage advances when it is empty or the stage downstream advances.
- Pipeline: 2 stages, latency 2 cycles from input transfer to out_valid, 1 sample/cycle sustained.
  - Stage 1 registers s1_a = p0+p1 and s1_b = p2+p3, sign-extended to SUM_W. It also registers the last-flag for the beat.
  - Stage 2 computes t = s1_a + s1_b + 2^(SHIFT-1), then r = t >>> SHIFT (arithmetic shift).
  - Stage 2 clips r: r<0 → 0; r>2^BIT_DEPTH-1 → 2^BIT_DEPTH-1; else r. The clipped value is registered into out_pix.
  - Stage 2 registers the last-flag into out_last.
- Sample counter (counts accepted input beats):
  - Increments on each input transfer.
  - Wraps N_SAMPLES-1 → 0; the beat at index N_SAMPLES-1 carries last-flag = 1.
- in_last consistency:
  - in_last at index N_SAMPLES-1: normal.
  - in_last at any other index: set err_sync (sticky until reset), force that beat's last-flag = 1, reset the counter to 0 (resync).
  - in_last = 0 at index N_SAMPLES-1: set err_sync; the counter still wraps and last-flag = 1.
- Simultaneous input transfer and output transfer: both happen and the pipeline shifts by one.
- No overflow is possible internally: |p| ≤ 2^(PROD_W-1), and the sum of 4 products fits in PROD_W+2 bits.
- Reset mid-row: in-flight samples are discarded and the counter restarts at 0. No out_valid is produced until new input arrives.

Decomposition:
- Shared package angular_pkg:
  - Constants FILTER_SHIFT=6, ROUND_OFS=32, ROW_SAMPLES=16.
  - Typedefs for the product word and the pixel word.
  - Function clip_pix(sum) → pixel.
- One natural sub-module: filt_pipe_stage. It is a generic valid/ready register slice with a data payload and is instantiated twice.

Test Plan:
- Unit tap: p1=6400, others 0, one beat → out_pix=100 exactly 2 cycles later; out_last=0.
- Rounding boundary:
  - Sum = 95 → out_pix = 1.
  - Sum = 96 → out_pix = 2.
  - Sum = -33 → out_pix = 0.
  - Sum = -32 → out_pix = 0.
- Clipping:
  - p0=-765, p1=p2=p3=0 → out_pix = 0.
  - p0=p1=p2=p3=4250 (sum 17000) → out_pix = 255.
- Full row, back-to-back with out_ready=1: 16 beats with in_last on beat 15 → 16 outputs on consecutive cycles; out_last only on output 15; err_sync=0; in_ready never drops.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming. in_ready drops after the two stages fill; out_pix/out_last stay stable.
  - Release out_ready: no sample lost or duplicated; output order is preserved.
- Sync error:
  - in_last on beat 5 → err_sync=1 stays set; output 5 has out_last=1.
  - The next row's beat 15 gives out_last=1 again.
  - Asserting rst_n=0 mid-stream clears out_valid and err_sync immediately (asynchronously).

Source files
------------

// File: rtl/angular_filter_accum_pkg.sv
// Shared constants, word types and the pixel clipping helper for the intra
// angular filter accumulator.
package angular_pkg;

    localparam int FILTER_SHIFT = 6;
    localparam int ROUND_OFS    = 32;
    localparam int ROW_SAMPLES  = 16;
    localparam int PROD_BITS    = 16;
    localparam int PIX_BITS     = 8;

    typedef logic signed [PROD_BITS-1:0] prod_t;
    typedef logic        [PIX_BITS-1:0]  pix_t;

    // Saturate a normalised sum into [0, max_pix].
    function automatic int clip_pix(input int r, input int max_pix);
        if (r < 0) begin
            return 0;
        end else if (r > max_pix) begin
            return max_pix;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/angular_filter_accum_stage.sv
// Generic valid/ready register slice; accepts a new payload whenever it is
// empty or its current payload is leaving downstream on the same edge.
module filt_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        up_ready_o = !valid_q || dn_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/angular_filter_accum.sv
// Four-tap product accumulator: pairwise sums, rounding, normalisation and
// pixel clipping over a 2-stage valid/ready pipeline with row sample tracking.
module angular_filter_accum
    import angular_pkg::*;
#(
    parameter int PROD_W    = PROD_BITS,
    parameter int SUM_W     = 18,
    parameter int SHIFT     = FILTER_SHIFT,
    parameter int BIT_DEPTH = PIX_BITS,
    parameter int N_SAMPLES = ROW_SAMPLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_p0,
    input  logic signed [PROD_W-1:0] in_p1,
    input  logic signed [PROD_W-1:0] in_p2,
    input  logic signed [PROD_W-1:0] in_p3,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_DEPTH-1:0]     out_pix,
    output logic                     out_last,
    output logic                     err_sync
);

    localparam int CNT_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int S1_W    = 2 * SUM_W + 1;
    localparam int S2_W    = BIT_DEPTH + 1;
    localparam int T_W     = SUM_W + 1;
    localparam int RND     = 1 << (SHIFT - 1);
    localparam int MAX_PIX = (1 << BIT_DEPTH) - 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{(SUM_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    in_fire, at_end, beat_last;
    logic signed [SUM_W-1:0] a_in, b_in;

    logic                    s1_valid, s2_ready;
    logic [S1_W-1:0]         s1_in, s1_data;
    logic                    s1_last;
    logic signed [SUM_W-1:0] s1_a, s1_b;
    logic signed [T_W-1:0]   t_sum, r_sh;
    logic [BIT_DEPTH-1:0]    pix_clip;
    logic [S2_W-1:0]         s2_in, s2_data;

    assign in_fire = in_valid && in_ready;
    assign a_in    = sext(in_p0) + sext(in_p1);
    assign b_in    = sext(in_p2) + sext(in_p3);

    // A premature in_last resynchronises the row; a missing one only flags.
    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        at_end    = (cnt_q == LAST_IDX);
        beat_last = at_end || in_last;
        if (in_fire) begin
            if (at_end) begin
                cnt_d = '0;
                if (!in_last) begin
                    err_d = 1'b1;
                end
            end else if (in_last) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign s1_in = {beat_last, a_in, b_in};

    filt_pipe_stage #(.W(S1_W)) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (in_valid),
        .up_ready_o (in_ready),
        .up_data_i  (s1_in),
        .dn_valid_o (s1_valid),
        .dn_ready_i (s2_ready),
        .dn_data_o  (s1_data)
    );

    // One guard bit on t: the largest positive sum plus the offset exceeds SUM_W.
    always_comb begin
        s1_last  = s1_data[S1_W-1];
        s1_a     = s1_data[2*SUM_W-1:SUM_W];
        s1_b     = s1_data[SUM_W-1:0];
        t_sum    = T_W'(s1_a) + T_W'(s1_b) + T_W'(RND);
        r_sh     = t_sum >>> SHIFT;
        pix_clip = BIT_DEPTH'(clip_pix(int'(r_sh), MAX_PIX));
        s2_in    = {s1_last, pix_clip};
    end

    filt_pipe_stage #(.W(S2_W)) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (s1_valid),
        .up_ready_o (s2_ready),
        .up_data_i  (s2_in),
        .dn_valid_o (out_valid),
        .dn_ready_i (out_ready),
        .dn_data_o  (s2_data)
    );

    assign out_last = s2_data[S2_W-1];
    assign out_pix  = s2_data[BIT_DEPTH-1:0];
    assign err_sync = err_q;

endmodule

// File: tb/tb_angular_filter_accum.sv
// Randomised and directed bench for angular_filter_accum with a queue-based
// arithmetic reference model.
module tb_angular_filter_accum;

    localparam int NS = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_last;
    logic signed [15:0] p0, p1, p2, p3;
    logic               out_valid, out_ready, out_last, err_sync;
    logic [7:0]         out_pix;

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    exp_t       q[$];
    int         nchecks = 0;
    int         nerrors = 0;
    int         m_idx = 0;
    bit         m_err = 1'b0;
    bit         last_took = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] hold_pix;
    logic       hold_last;
    int         npop = 0;

    always #5 clk = ~clk;

    angular_filter_accum #(
        .PROD_W(16), .SUM_W(18), .SHIFT(6), .BIT_DEPTH(8), .N_SAMPLES(NS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p0(p0), .in_p1(p1), .in_p2(p2), .in_p3(p3), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_last(out_last), .err_sync(err_sync)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // round(sum / 64) with ties upward, then saturate to 0..255
    function automatic logic [7:0] ref_pix(input int s);
        int v;
        int r;
        v = s + 32;
        if (v >= 0) r = v / 64;
        else        r = -((-v + 63) / 64);
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r[7:0];
    endfunction

    task automatic model_push();
        exp_t e;
        e.pix = ref_pix(int'(p0) + int'(p1) + int'(p2) + int'(p3));
        if (m_idx == NS - 1) begin
            e.last = 1'b1;
            m_idx  = 0;
            if (!in_last) m_err = 1'b1;
        end else if (in_last) begin
            e.last = 1'b1;
            m_idx  = 0;
            m_err  = 1'b1;
        end else begin
            e.last = 1'b0;
            m_idx++;
        end
        q.push_back(e);
    endtask

    // Observe at the falling edge, then advance past the next rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_took = 1'b0;
        check("err_sync", err_sync, m_err);
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_pix", out_pix, hold_pix);
            check("hold_last", out_last, hold_last);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", out_valid, 0);
            end else if (out_ready) begin
                e = q.pop_front();
                npop++;
                check("out_pix", out_pix, e.pix);
                check("out_last", out_last, e.last);
            end
        end
        stall_prev = out_valid && !out_ready;
        hold_pix   = out_pix;
        hold_last  = out_last;
        if (in_valid && in_ready) begin
            model_push();
            last_took = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input int d, input bit l);
        p0 = a[15:0]; p1 = b[15:0]; p2 = c[15:0]; p3 = d[15:0];
        in_last  = l;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (last_took) break;
        end
        check("send_accept", last_took, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) break;
            cycle();
        end
        check("drain_empty", q.size(), 0);
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_err", err_sync, 0);
        check("rst_pix", out_pix, 0);
        check("rst_last", out_last, 0);
        in_valid = 1'b0;
        q.delete();
        m_idx = 0;
        m_err = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        int start_pop;
        logic [31:0] rnd;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
        #3;
        check("reset_valid", out_valid, 0);
        check("reset_pix", out_pix, 0);
        check("reset_last", out_last, 0);
        check("reset_err", err_sync, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // unit tap with explicit latency
        send(0, 6400, 0, 0, 1'b0);
        in_valid = 1'b0;
        check("lat1_valid", out_valid, 0);
        cycle();
        check("lat2_valid", out_valid, 1);
        check("lat2_pix", out_pix, 100);
        check("lat2_last", out_last, 0);
        drain();

        // rounding and clipping boundaries
        send(95, 0, 0, 0, 1'b0);
        send(50, 46, 0, 0, 1'b0);
        send(-33, 0, 0, 0, 1'b0);
        send(0, 0, -32, 0, 1'b0);
        send(-765, 0, 0, 0, 1'b0);
        send(4250, 4250, 4250, 4250, 1'b0);
        send(32767, 32767, 32767, 32767, 1'b0);
        send(-32768, -32768, -32768, -32768, 1'b0);
        drain();

        // full row back-to-back
        do_reset();
        start_pop = npop;
        for (int i = 0; i < NS; i++) begin
            check("row_in_ready", in_ready, 1);
            rnd = $urandom;
            send(int'(rnd[9:0]) * 8, int'(rnd[19:10]) * 4, int'(rnd[29:20]), 0, i == NS - 1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        check("row_outputs", npop - start_pop, NS);
        drain();

        // backpressure: stream while downstream stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0 || last_took) begin
                rnd = $urandom;
                p0 = rnd[15:0]; p1 = rnd[31:16]; p2 = 16'sd1000; p3 = -16'sd200;
            end
            cycle();
        end
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (last_took) begin
                rnd = $urandom;
                p0 = rnd[15:0]; p1 = 16'sd3000; p2 = rnd[31:16]; p3 = 16'sd0;
            end
            cycle();
        end
        drain();

        // early in_last, then a clean row after resync
        do_reset();
        for (int i = 0; i < 6; i++) send(i * 700, 100, 0, 0, i == 5);
        for (int i = 0; i < NS; i++) send(i * 900, 0, 50, 0, i == NS - 1);
        drain();
        check("err_sticky", err_sync, 1);

        // randomised traffic
        in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || last_took) begin
                rnd = $urandom; p0 = rnd[15:0]; p1 = rnd[31:16];
                rnd = $urandom; p2 = rnd[15:0]; p3 = rnd[31:16];
                if (k < 200) begin
                    p0 = p0 >>> 4; p1 = p1 >>> 4; p2 = p2 >>> 4; p3 = p3 >>> 4;
                end
                in_valid = ($urandom_range(0, 3) != 0);
                in_last  = ($urandom_range(0, 11) == 0);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();

        // asynchronous reset in the middle of a stream
        in_valid = 1'b1;
        in_last  = 1'b1;
        send(6400, 0, 0, 0, 1'b1);
        send(1280, 0, 0, 0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("post_rst_idle", out_valid, 0);
        end
        send(64, 64, 64, 64, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
